// File: rtl/mac_vec_ctrl_pkg.sv
// Shared types and defaults for the MAC vector sequencer.
// The drain depth is the operand-path latency from last read to last MAC pair.
package mac_vec_ctrl_pkg;

    localparam int DATA_W_DFLT = 8;
    localparam int ACC_W_DFLT  = 32;
    localparam int ADDR_W_DFLT = 6;
    localparam int DRAIN_DEPTH = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_WAIT_MAC = 3'd3,
        ST_OUT      = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/mac_operand_stage.sv
// One-cycle register between the operand buffers and the MAC inputs.
// Operands are forced to zero whenever the MAC is not enabled.
module mac_operand_stage
    import mac_vec_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_vld_i,
    input  logic              rd_last_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [DATA_W-1:0] w_data_i,
    output logic              mac_enable_o,
    output logic [DATA_W-1:0] mac_input_o,
    output logic [DATA_W-1:0] mac_weight_o,
    output logic              mac_valid_o
);

    logic              r_enable;
    logic              r_valid;
    logic [DATA_W-1:0] r_input;
    logic [DATA_W-1:0] r_weight;

    // Capture the returned operand pair and its strobes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_enable <= 1'b0;
            r_valid  <= 1'b0;
            r_input  <= {DATA_W{1'b0}};
            r_weight <= {DATA_W{1'b0}};
        end else if (rd_vld_i) begin
            r_enable <= 1'b1;
            r_valid  <= rd_last_i;
            r_input  <= in_data_i;
            r_weight <= w_data_i;
        end else begin
            r_enable <= 1'b0;
            r_valid  <= 1'b0;
            r_input  <= {DATA_W{1'b0}};
            r_weight <= {DATA_W{1'b0}};
        end
    end

    assign mac_enable_o = r_enable;
    assign mac_valid_o  = r_valid;
    assign mac_input_o  = r_input;
    assign mac_weight_o = r_weight;

endmodule

// File: rtl/mac_vec_ctrl.sv
// Sequencer for one MAC lane: fetches operand pairs, streams them to the MAC,
// then holds the accumulated result for a valid/ready consumer.
module mac_vec_ctrl
    import mac_vec_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int ACC_W  = ACC_W_DFLT,
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [DATA_W-1:0] w_data_i,
    output logic              mac_enable_o,
    output logic [DATA_W-1:0] mac_input_o,
    output logic [DATA_W-1:0] mac_weight_o,
    output logic              mac_valid_o,
    input  logic              mac_valid_i,
    input  logic [ACC_W-1:0]  mac_result_i,
    output logic [ACC_W-1:0]  result_o,
    output logic              result_valid_o,
    input  logic              result_ready_i
);

    localparam logic [LEN_W-1:0]  MAX_LEN    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]        DRAIN_LAST = 2'(DRAIN_DEPTH - 1);

    ctrl_state_t       r_state;
    ctrl_state_t       w_state_nxt;

    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_last_addr;
    logic [1:0]        r_drain_cnt;
    logic              r_rd_en;
    logic              r_busy;
    logic              r_res_valid;
    logic              r_rd_vld_d;
    logic              r_rd_last_d;
    logic [ACC_W-1:0]  r_result;

    logic [ADDR_W-1:0] w_last_addr;
    logic              w_len_zero;
    logic              w_len_sat;
    logic              w_addr_last;
    logic              w_drain_done;
    logic              w_rd_en_nxt;
    logic              w_busy_nxt;
    logic              w_res_valid_nxt;

    // Oversized lengths clamp to the full buffer, i.e. last address all-ones.
    assign w_len_zero   = (len_i == {LEN_W{1'b0}});
    assign w_len_sat    = (len_i >= MAX_LEN);
    assign w_last_addr  = w_len_sat ? {ADDR_W{1'b1}} : (len_i[ADDR_W-1:0] - ADDR_ONE);
    assign w_addr_last  = (r_rd_addr == r_last_addr);
    assign w_drain_done = (r_drain_cnt == DRAIN_LAST);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_nxt = w_len_zero ? ST_OUT : ST_FETCH;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (w_addr_last) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (w_drain_done) begin
                    w_state_nxt = ST_WAIT_MAC;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_WAIT_MAC: begin
                if (mac_valid_i) begin
                    w_state_nxt = ST_OUT;
                end else begin
                    w_state_nxt = ST_WAIT_MAC;
                end
            end
            ST_OUT: begin
                if (result_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_OUT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the status outputs can be registered.
    always_comb begin
        w_rd_en_nxt     = 1'b0;
        w_busy_nxt      = 1'b0;
        w_res_valid_nxt = 1'b0;
        case (w_state_nxt)
            ST_FETCH: begin
                w_rd_en_nxt = 1'b1;
                w_busy_nxt  = 1'b1;
            end
            ST_DRAIN, ST_WAIT_MAC: begin
                w_busy_nxt = 1'b1;
            end
            ST_OUT: begin
                w_busy_nxt      = 1'b1;
                w_res_valid_nxt = 1'b1;
            end
            default: begin
                w_rd_en_nxt     = 1'b0;
                w_busy_nxt      = 1'b0;
                w_res_valid_nxt = 1'b0;
            end
        endcase
    end

    // Status outputs and the read-strobe delay aligned with returning data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_en     <= 1'b0;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
            r_rd_vld_d  <= 1'b0;
            r_rd_last_d <= 1'b0;
        end else begin
            r_rd_en     <= w_rd_en_nxt;
            r_busy      <= w_busy_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_rd_vld_d  <= r_rd_en;
            r_rd_last_d <= r_rd_en & w_addr_last;
        end
    end

    // Address counter, latched last address and drain counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_addr   <= {ADDR_W{1'b0}};
            r_last_addr <= {ADDR_W{1'b0}};
            r_drain_cnt <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rd_addr   <= {ADDR_W{1'b0}};
                    r_drain_cnt <= 2'd0;
                    if (start_i) begin
                        r_last_addr <= w_last_addr;
                    end
                end
                ST_FETCH: begin
                    r_rd_addr <= w_addr_last ? {ADDR_W{1'b0}} : (r_rd_addr + ADDR_ONE);
                end
                ST_DRAIN: begin
                    r_drain_cnt <= w_drain_done ? 2'd0 : (r_drain_cnt + 2'd1);
                end
                default: begin
                    r_rd_addr   <= {ADDR_W{1'b0}};
                    r_drain_cnt <= 2'd0;
                end
            endcase
        end
    end

    // Result latch; a zero-length vector yields zero without involving the MAC.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_result <= {ACC_W{1'b0}};
        end else if ((r_state == ST_IDLE) && start_i && w_len_zero) begin
            r_result <= {ACC_W{1'b0}};
        end else if ((r_state == ST_WAIT_MAC) && mac_valid_i) begin
            r_result <= mac_result_i;
        end
    end

    mac_operand_stage #(
        .DATA_W (DATA_W)
    ) u_operand_stage (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rd_vld_i     (r_rd_vld_d),
        .rd_last_i    (r_rd_last_d),
        .in_data_i    (in_data_i),
        .w_data_i     (w_data_i),
        .mac_enable_o (mac_enable_o),
        .mac_input_o  (mac_input_o),
        .mac_weight_o (mac_weight_o),
        .mac_valid_o  (mac_valid_o)
    );

    assign busy_o         = r_busy;
    assign rd_en_o        = r_rd_en;
    assign rd_addr_o      = r_rd_addr;
    assign result_o       = r_result;
    assign result_valid_o = r_res_valid;

endmodule

// File: doc/mac_vec_ctrl.md
# mac_vec_ctrl

Sequencer for the signed 8-bit MAC in the vector multiplier. On a start command it reads `len` operand pairs (input and weight) from the two operand buffers, streams them into the MAC one pair per cycle, and flags the last pair with `mac_valid_o`. It then waits for the MAC's accumulated result and presents it to the matrix-level logic with a valid/ready handshake. It sits between the operand buffers and the MAC, one instance per MAC lane.

## Interface
- `DATA_W`, 8: operand width (signed).
- `ACC_W`, 32: MAC result width (signed).
- `ADDR_W`, 6: operand buffer address width; maximum vector length is 2^ADDR_W.
- `LEN_W`, `ADDR_W+1`: width of the length field.

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `start_i` in 1: start pulse; sampled only in IDLE.
- `len_i` in LEN_W: vector length, sampled with `start_i`.
- `busy_o` out 1: high from the cycle after start acceptance until the result handshake completes.
- `rd_en_o` out 1: read strobe to both operand buffers.
- `rd_addr_o` out ADDR_W: shared read address.
- `in_data_i` in DATA_W: input-vector read data, valid 1 cycle after `rd_en_o`.
- `w_data_i` in DATA_W: weight-vector read data, same timing as `in_data_i`.
- `mac_enable_o` out 1: drives MAC `dsp_enable_i`.
- `mac_input_o` out DATA_W: drives MAC `dsp_input_i`.
- `mac_weight_o` out DATA_W: drives MAC `dsp_weight_i`.
- `mac_valid_o` out 1: drives MAC `dsp_valid_i`; marks the last pair.
- `mac_valid_i` in 1: from MAC `dsp_valid_o`.
- `mac_result_i` in ACC_W: from MAC `dsp_output_o`.
- `result_o` out ACC_W: latched dot product.
- `result_valid_o` out 1: result available.
- `result_ready_i` in 1: consumer accepts the result.

## Operation
- **FSM states:** IDLE, FETCH, DRAIN, WAIT_MAC, OUT.
- **IDLE:**
  - `start_i=1` with `len_i≥1`: latch `len` → FETCH.
  - `start_i=1` with `len_i=0`: load `result_o=0` → OUT. The MAC is never touched.
  - `len_i > 2^ADDR_W` saturates to 2^ADDR_W.
- **FETCH:**
  - `rd_en_o=1`; `rd_addr_o` counts 0..len-1, one address per cycle.
  - Leaves for DRAIN after issuing address len-1.
- **Operand stage (always active):**
  - Registers the read data returned one cycle after each read. The next cycle it drives `mac_enable_o=1`, `mac_input_o=in_data_i`, `mac_weight_o=w_data_i`.
  - `mac_valid_o=1` only together with the pair read from address len-1.
  - When not enabled: `mac_input_o` and `mac_weight_o` are 0.
- **DRAIN:**
  - No reads.
  - Stays until the last pair has been driven (2 cycles), then → WAIT_MAC.
- **WAIT_MAC:**
  - On `mac_valid_i=1`: latch `mac_result_i` into `result_o` → OUT.
  - There is no timeout.
- **OUT:**
  - `result_valid_o=1`; `result_o` is held stable.
  - On `result_ready_i=1`: → IDLE.
- **Ignored inputs:** `start_i` outside IDLE; `mac_valid_i` outside WAIT_MAC.
- **Arithmetic:** none is done in this block. Operands pass through unchanged; the result is passed through at ACC_W.

## Timing
- Start accepted at cycle T:
  - `rd_en_o` high in cycles T+1..T+len, with `rd_addr_o=k` in cycle T+1+k.
  - `mac_enable_o` high in cycles T+3..T+len+2, one contiguous burst.
  - `mac_valid_o` high in cycle T+len+2 only.
- MAC result arrives at cycle R (`mac_valid_i`) → `result_valid_o` rises at R+1.
- Handshake completes at cycle H (`result_valid_o` & `result_ready_i`) → IDLE at H+1, and `busy_o=0` at H+1.
  - A new `start_i` can be accepted at H+1.
- `len=0`: `result_valid_o=1` at T+1 with `result_o=0`.
- **Reset values:** every output is 0 and the state is IDLE, including when `rst_i` is asserted mid-operation.
  - Any in-flight read data is discarded.
  - The system must reset the MAC at the same time; the controller cannot clear the MAC accumulator.

## Structure
- **Package `mac_vec_ctrl_pkg`:**
  - FSM state enum.
  - Default `DATA_W`, `ACC_W`, `ADDR_W`.
  - Drain-depth constant (2).
- **Sub-module `mac_operand_stage`:**
  - One-cycle register that turns the read data plus a delayed read strobe and delayed last flag into the `mac_*` outputs.
  - Has its own synchronous reset.
- The FSM, address counter and result latch stay in the top module.

## Test plan
- **Basic vector:** len=8, in=1..8, w=-1 → 8 contiguous `mac_enable_o` cycles starting at T+3; `mac_valid_o` on the 8th cycle; `result_o=-36` one cycle after `mac_valid_i`.
- **Single element:** len=1, in=-128, w=-128 → one enable cycle with `mac_valid_o` at T+3; `result_o=16384`.
- **Zero length:** len=0 → `result_valid_o` at T+1 with 0; `rd_en_o` and `mac_enable_o` never assert.
- **Backpressure:** hold `result_ready_i=0` for 5 cycles → `result_o` stable and `busy_o=1` throughout; a `start_i` pulse during this window is ignored; IDLE one cycle after ready rises.
- **Reset mid-operation:** assert `rst_i` after address 3 has been issued → all outputs 0 on the next cycle; a new len=4 run with in=w=2 yields `result_o=16`.
- **Full length:** len=64, in=w=127 → addresses 0..63 with no gap; `mac_valid_o` with the address-63 pair; `result_o=1032256`. Also apply len=100 and check it behaves as len=64.
